vreg_file_mb: RTL and testbench

Parametrised scalar/vector register file with two read ports, a lane-masked primary write port and a multi-beat fill port for lane-serial vector loads. A per-register busy scoreboard tracks in-flight fills and stalls reads of registers still being filled. The block sits in the decode/operand-fetch stage of the SIMD datapath. It supplies lane-packed operands in which the top lane carries the scalar operand.

---
 rtl/vrf_pkg.sv | 22 ++
 rtl/vrf_fill_ctrl.sv | 93 +++++++++
 rtl/vreg_file_mb.sv | 112 +++++++++++
 tb/tb_vreg_file_mb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// rtl/vrf_pkg.sv - shared defaults, derived widths and fill-state enum for vreg_file_mb
package vrf_pkg;

  localparam int DEF_LANES      = 16;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_NREGS      = 16;
  localparam int DEF_BEAT_LANES = 4;

  localparam int DEF_AW    = $clog2(DEF_NREGS);
  localparam int DEF_BEATS = DEF_LANES / DEF_BEAT_LANES;

  typedef enum logic {
    FILL_IDLE   = 1'b0,
    FILL_ACTIVE = 1'b1
  } fill_state_t;

  // A single-beat fill still needs a one-bit counter.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/vrf_fill_ctrl.sv
// rtl/vrf_fill_ctrl.sv - fill FSM, beat counter, latched destination and busy scoreboard
module vrf_fill_ctrl
  import vrf_pkg::*;
#(
  parameter int  LANES      = DEF_LANES,
  parameter int  NREGS      = DEF_NREGS,
  parameter int  BEAT_LANES = DEF_BEAT_LANES,
  localparam int AW         = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fill_start_valid,
  output logic             fill_start_ready,
  input  logic [AW-1:0]    fill_reg,
  input  logic             fill_valid,
  output logic             fill_ready,
  input  logic             fill_abort,
  output logic             fill_done,
  output logic [NREGS-1:0] busy,
  output logic [LANES-1:0] fill_lane_we,
  output logic [AW-1:0]    fill_dst
);

  localparam int BEATS = LANES / BEAT_LANES;
  localparam int CW    = cnt_width(BEATS);
  localparam logic [LANES-1:0] BEAT_MASK = LANES'({BEAT_LANES{1'b1}});

  fill_state_t      state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [AW-1:0]    dst, dst_nx;
  logic [NREGS-1:0] busy_nx;
  logic             done_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL_IDLE;
      cnt       <= '0;
      dst       <= '0;
      busy      <= '0;
      fill_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      dst       <= dst_nx;
      busy      <= busy_nx;
      fill_done <= done_nx;
    end
  end

  always_comb begin
    state_nx         = state;
    cnt_nx           = cnt;
    dst_nx           = dst;
    busy_nx          = busy;
    done_nx          = 1'b0;
    fill_start_ready = 1'b0;
    fill_ready       = 1'b0;
    fill_lane_we     = '0;
    case (state)
      FILL_IDLE: begin
        fill_start_ready = 1'b1;
        if (fill_start_valid) begin
          dst_nx            = fill_reg;
          busy_nx[fill_reg] = 1'b1;
          cnt_nx            = '0;
          state_nx          = FILL_ACTIVE;
        end
      end
      FILL_ACTIVE: begin
        fill_ready = 1'b1;
        // Abort wins over a beat presented in the same cycle.
        if (fill_abort) begin
          busy_nx[dst] = 1'b0;
          state_nx     = FILL_IDLE;
        end else if (fill_valid) begin
          fill_lane_we = BEAT_MASK << (32'(cnt) * BEAT_LANES);
          if (cnt == CW'(BEATS - 1)) begin
            busy_nx[dst] = 1'b0;
            done_nx      = 1'b1;
            cnt_nx       = '0;
            state_nx     = FILL_IDLE;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: state_nx = FILL_IDLE;
    endcase
  end

  assign fill_dst = dst;

endmodule

// File: rtl/vreg_file_mb.sv
// rtl/vreg_file_mb.sv - scalar/vector register file with masked write port and multi-beat fill port
module vreg_file_mb
  import vrf_pkg::*;
#(
  parameter int  LANES      = DEF_LANES,
  parameter int  DATA_W     = DEF_DATA_W,
  parameter int  NREGS      = DEF_NREGS,
  parameter int  BEAT_LANES = DEF_BEAT_LANES,
  localparam int AW         = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [AW-1:0]                ra1,
  input  logic [AW-1:0]                ra2,
  input  logic                         rsel_v,
  input  logic [DATA_W-1:0]            pc_in,
  output logic [LANES*DATA_W-1:0]      rd1,
  output logic [LANES*DATA_W-1:0]      rd2,
  output logic                         rd_stall,
  input  logic                         we,
  input  logic [AW-1:0]                wa,
  input  logic                         wsel_v,
  input  logic [LANES-1:0]             wmask,
  input  logic [LANES*DATA_W-1:0]      wd,
  input  logic                         fill_start_valid,
  output logic                         fill_start_ready,
  input  logic [AW-1:0]                fill_reg,
  input  logic                         fill_valid,
  output logic                         fill_ready,
  input  logic [BEAT_LANES*DATA_W-1:0] fill_data,
  input  logic                         fill_abort,
  output logic                         fill_done
);

  localparam int TOP = LANES - 1;

  logic [DATA_W-1:0] vec_mem  [NREGS][LANES];
  logic [DATA_W-1:0] scal_mem [NREGS-1];

  logic [NREGS-1:0] busy;
  logic [LANES-1:0] fill_lane_we;
  logic [AW-1:0]    fill_dst;

  vrf_fill_ctrl #(
    .LANES      (LANES),
    .NREGS      (NREGS),
    .BEAT_LANES (BEAT_LANES)
  ) u_fill (
    .clk              (clk),
    .rst_n            (rst_n),
    .fill_start_valid (fill_start_valid),
    .fill_start_ready (fill_start_ready),
    .fill_reg         (fill_reg),
    .fill_valid       (fill_valid),
    .fill_ready       (fill_ready),
    .fill_abort       (fill_abort),
    .fill_done        (fill_done),
    .busy             (busy),
    .fill_lane_we     (fill_lane_we),
    .fill_dst         (fill_dst)
  );

  // Fill writes are issued first so a primary write to the same lane overrides them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        for (int l = 0; l < LANES; l++)
          vec_mem[r][l] <= '0;
      for (int r = 0; r < NREGS - 1; r++)
        scal_mem[r] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++)
        if (fill_lane_we[l])
          vec_mem[fill_dst][l] <= fill_data[(l % BEAT_LANES)*DATA_W +: DATA_W];
      for (int l = 0; l < LANES; l++)
        if (we && wsel_v && wmask[l])
          vec_mem[wa][l] <= wd[l*DATA_W +: DATA_W];
      if (we && !wsel_v && (wa != AW'(NREGS - 1)))
        scal_mem[wa] <= wd[TOP*DATA_W +: DATA_W];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [AW-1:0]           addr;
    logic                    byp;
    logic [LANES*DATA_W-1:0] data;

    assign addr = (p == 0) ? ra1 : ra2;
    assign byp  = we && (wsel_v == rsel_v) && (wa == addr);

    always_comb begin
      data = '0;
      for (int l = 0; l < TOP; l++)
        data[l*DATA_W +: DATA_W] = (byp && wsel_v && wmask[l]) ? wd[l*DATA_W +: DATA_W]
                                                               : vec_mem[addr][l];
      if (rsel_v)
        data[TOP*DATA_W +: DATA_W] = (byp && wmask[TOP]) ? wd[TOP*DATA_W +: DATA_W]
                                                         : vec_mem[addr][TOP];
      else if (addr == AW'(NREGS - 1))
        data[TOP*DATA_W +: DATA_W] = pc_in;
      else if (byp)
        data[TOP*DATA_W +: DATA_W] = wd[TOP*DATA_W +: DATA_W];
      else
        data[TOP*DATA_W +: DATA_W] = scal_mem[addr];
    end
  end

  assign rd1      = g_rd[0].data;
  assign rd2      = g_rd[1].data;
  assign rd_stall = rsel_v & (busy[ra1] | busy[ra2]);

endmodule

// File: tb/tb_vreg_file_mb.sv
// tb/tb_vreg_file_mb.sv - randomized bench for vreg_file_mb against a lane-array reference model
module tb_vreg_file_mb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   ra1, ra2, wa, fill_reg;
  logic         rsel_v, we, wsel_v;
  logic [31:0]  pc_in;
  logic [511:0] rd1, rd2, wd;
  logic         rd_stall;
  logic [15:0]  wmask;
  logic         fill_start_valid, fill_start_ready, fill_valid, fill_ready, fill_abort, fill_done;
  logic [127:0] fill_data;

  int n_vec = 0;
  int n_err = 0;

  vreg_file_mb dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rsel_v(rsel_v), .pc_in(pc_in),
    .rd1(rd1), .rd2(rd2), .rd_stall(rd_stall), .we(we), .wa(wa), .wsel_v(wsel_v),
    .wmask(wmask), .wd(wd), .fill_start_valid(fill_start_valid),
    .fill_start_ready(fill_start_ready), .fill_reg(fill_reg), .fill_valid(fill_valid),
    .fill_ready(fill_ready), .fill_data(fill_data), .fill_abort(fill_abort),
    .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  // Reference model: plain register arrays plus "which register is being filled, which beat next".
  logic [31:0] m_vec  [16][16];
  logic [31:0] m_scal [15];
  bit          m_active;
  int          m_dst, m_beat;
  bit          m_done;

  task automatic model_reset();
    for (int r = 0; r < 16; r++) for (int l = 0; l < 16; l++) m_vec[r][l] = '0;
    for (int r = 0; r < 15; r++) m_scal[r] = '0;
    m_active = 0; m_dst = 0; m_beat = 0; m_done = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (fill_start_valid) begin
          m_active = 1; m_dst = int'(fill_reg); m_beat = 0;
        end
      end else if (fill_abort) begin
        m_active = 0;
      end else if (fill_valid) begin
        for (int j = 0; j < 4; j++) m_vec[m_dst][m_beat*4 + j] = fill_data[j*32 +: 32];
        m_beat++;
        if (m_beat == 4) begin m_active = 0; m_done = 1; end
      end
      if (we && wsel_v) begin
        for (int l = 0; l < 16; l++) if (wmask[l]) m_vec[wa][l] = wd[l*32 +: 32];
      end else if (we && wa != 4'd15) begin
        m_scal[wa] = wd[480 +: 32];
      end
    end
  end

  function automatic logic [511:0] exp_rd(input logic [3:0] a);
    logic [511:0] r;
    bit byp;
    byp = we && (wsel_v == rsel_v) && (wa == a);
    for (int l = 0; l < 15; l++)
      r[l*32 +: 32] = (byp && rsel_v && wmask[l]) ? wd[l*32 +: 32] : m_vec[a][l];
    if (rsel_v)        r[480 +: 32] = (byp && wmask[15]) ? wd[480 +: 32] : m_vec[a][15];
    else if (a == 15)  r[480 +: 32] = pc_in;
    else if (byp)      r[480 +: 32] = wd[480 +: 32];
    else               r[480 +: 32] = m_scal[a];
    return r;
  endfunction

  function automatic logic [511:0] lanes(input logic [31:0] v, input logic [15:0] m);
    logic [511:0] r = '0;
    for (int l = 0; l < 16; l++) if (m[l]) r[l*32 +: 32] = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("rd1", rd1, exp_rd(ra1));
      check("rd2", rd2, exp_rd(ra2));
      check("rd_stall", rd_stall,
            rsel_v && m_active && (m_dst == int'(ra1) || m_dst == int'(ra2)));
      check("fill_start_ready", fill_start_ready, !m_active);
      check("fill_ready", fill_ready, m_active);
      check("fill_done", fill_done, m_done);
    end
  end

  task automatic cyc();  @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); #1; endtask

  task automatic idle();
    we = 0; wsel_v = 0; wa = 0; wmask = '0; wd = '0;
    fill_start_valid = 0; fill_reg = 0; fill_valid = 0; fill_data = '0; fill_abort = 0;
  endtask

  initial begin
    logic [511:0] e;
    model_reset();
    idle();
    ra1 = 0; ra2 = 0; rsel_v = 0; pc_in = 32'h100;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // reset state
    rsel_v = 1; ra1 = 3; look();
    check("rst_vec3", rd1, '0);
    check("rst_start_ready", fill_start_ready, 1'b1);
    check("rst_fill_ready", fill_ready, 1'b0);
    cyc(); rsel_v = 0; ra1 = 15; look();
    check("rst_pc", rd1[480 +: 32], 32'h100);
    check("rst_stall", rd_stall, 1'b0);

    // masked vector write with same-cycle bypass
    cyc(); we = 1; wsel_v = 1; wa = 2; wmask = 16'h00FF; wd = lanes(32'hA5, 16'hFFFF);
    rsel_v = 1; ra1 = 2; look();
    check("bypass_mask", rd1, lanes(32'hA5, 16'h00FF));
    cyc(); we = 0; look();
    check("stored_mask", rd1, lanes(32'hA5, 16'h00FF));
    cyc(); we = 1; wsel_v = 0; wa = 15; wd = lanes(32'h9, 16'hFFFF); rsel_v = 0; ra1 = 15;
    cyc(); we = 0; look();
    check("pc_alias_ignored", rd1[480 +: 32], 32'h100);
    cyc(); we = 1; wa = 4; wd = lanes(32'h77, 16'hFFFF);
    cyc(); we = 0; ra1 = 4; look();
    check("scalar_wr", rd1, lanes(32'h77, 16'h8000));

    // full fill to reg 5
    cyc(); fill_start_valid = 1; fill_reg = 5; rsel_v = 1; ra1 = 5; look();
    check("fill_pre_stall", rd_stall, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(); fill_start_valid = 0; fill_valid = 1; fill_data = {4{32'(32'h10 + k)}}; look();
      check("fill_stall", rd_stall, 1'b1);
      check("fill_done_early", fill_done, 1'b0);
    end
    cyc(); fill_valid = 0; look();
    e = '0;
    for (int l = 0; l < 16; l++) e[l*32 +: 32] = 32'(32'h10 + l / 4);
    check("fill_done_pulse", fill_done, 1'b1);
    check("fill_after_stall", rd_stall, 1'b0);
    check("fill_data", rd1, e);
    cyc(); look();
    check("fill_done_once", fill_done, 1'b0);

    // gapped beats then abort on reg 6
    cyc(); fill_start_valid = 1; fill_reg = 6; ra1 = 6;
    cyc(); fill_start_valid = 0; fill_valid = 1; fill_data = {4{32'h20}};
    cyc(); fill_data = {4{32'h21}};
    cyc(); fill_valid = 0;
    for (int g = 0; g < 3; g++) begin
      look(); check("gap_stall", rd_stall, 1'b1);
      cyc();
    end
    fill_abort = 1; fill_valid = 1; fill_data = {4{32'h22}};
    cyc(); fill_abort = 0; fill_valid = 0; look();
    check("abort_no_done", fill_done, 1'b0);
    check("abort_stall", rd_stall, 1'b0);
    check("abort_idle", fill_start_ready, 1'b1);
    check("abort_data", rd1, lanes(32'h20, 16'h000F) | lanes(32'h21, 16'h00F0));

    // primary write collides with fill beat 0 on reg 7 lane 1
    cyc(); fill_start_valid = 1; fill_reg = 7;
    cyc(); fill_start_valid = 0; fill_valid = 1; fill_data = {4{32'h30}};
    we = 1; wsel_v = 1; wa = 7; wmask = 16'h0002; wd = lanes(32'hDEAD, 16'hFFFF);
    cyc(); we = 0; fill_valid = 0; fill_abort = 1;
    cyc(); fill_abort = 0; ra1 = 7; rsel_v = 1; look();
    check("collision", rd1, lanes(32'h30, 16'h000D) | lanes(32'hDEAD, 16'h0002));

    // reset during beat 2 of a fill to reg 5
    cyc(); fill_start_valid = 1; fill_reg = 5; ra1 = 5;
    cyc(); fill_start_valid = 0; fill_valid = 1; fill_data = {4{32'h40}};
    cyc(); fill_data = {4{32'h41}};
    cyc(); fill_data = {4{32'h42}};
    #2 rst_n = 0;
    #1;
    check("mid_rst_start_ready", fill_start_ready, 1'b1);
    check("mid_rst_fill_ready", fill_ready, 1'b0);
    check("mid_rst_stall", rd_stall, 1'b0);
    check("mid_rst_done", fill_done, 1'b0);
    check("mid_rst_data", rd1, '0);
    @(posedge clk); #1;
    idle(); rst_n = 1; look();
    check("post_rst_reg5", rd1, '0);

    // randomized traffic; the compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      cyc();
      ra1 = 4'($urandom_range(0, 15)); ra2 = 4'($urandom_range(0, 15));
      rsel_v = 1'($urandom); pc_in = $urandom;
      we = ($urandom_range(0, 2) == 0); wsel_v = 1'($urandom);
      wa = 4'($urandom_range(0, 15)); wmask = 16'($urandom);
      for (int l = 0; l < 16; l++) wd[l*32 +: 32] = $urandom;
      fill_start_valid = ($urandom_range(0, 3) == 0); fill_reg = 4'($urandom_range(0, 15));
      fill_valid = ($urandom_range(0, 9) < 7);
      for (int j = 0; j < 4; j++) fill_data[j*32 +: 32] = $urandom;
      fill_abort = ($urandom_range(0, 24) == 0);
    end
    cyc(); idle(); look();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
